elbeth_pipeline_control: RTL and testbench
==========================================

Name: elbeth_pipeline_control

Overview:
- Central hazard and sequencing controller for the 5-stage ELBETH pipeline.
- Drives the stall/flush controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken branches/jumps, instruction-memory wait and data-memory wait (with timeout).
- Keeps stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, number of consecutive data-memory wait cycles before the access is aborted.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- if_imem_ready  input  1  fetch response valid this cycle; the fetch unit holds it while pc_stall=1.
- id_rs1_addr  input  5  source register 1 of the instruction in ID.
- id_rs2_addr  input  5  source register 2 of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd_addr  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_take_branch  input  1  branch/jump resolved taken in EX.
- mem_dmem_request  input  1  MEM instruction accesses data memory.
- mem_dmem_ready  input  1  data memory completes the access this cycle.
- pc_stall  output  1  hold PC.
- ifid_stall, ifid_flush  output  1 each  IF/ID hold / zero (ctrl_stall / ctrl_flush).
- idex_stall, idex_flush  output  1 each  ID/EX hold / zero.
- exmem_stall, exmem_flush  output  1 each  EX/MEM hold / zero.
- memwb_stall, memwb_flush  output  1 each  MEM/WB hold / zero.
- bus_error  output  1  one-cycle pulse on data-memory timeout.
- stall_count  output  CNT_W  cycles with pc_stall=1, wraps.
- flush_count  output  CNT_W  taken redirects, wraps.

Behaviour:
- State machine: RUN, IDROP, DWAIT. Registered state with asynchronous reset to RUN.
- Stall/flush outputs are combinational from current state and live inputs, so they act in the same cycle.
- Registered outputs on reset: state=RUN, timeout counter=0, bus_error=0, stall_count=0, flush_count=0.
- In reset, all stall/flush outputs = 0.
- Reset mid-operation abandons any wait or drop immediately.
- Priority per cycle, highest first:
  1. Data wait. Condition: mem_dmem_request & !mem_dmem_ready, or state=DWAIT.
     - Outputs: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush.
     - ex_take_branch, load-use and if_imem_ready are ignored.
     - Enter or stay in DWAIT; the timeout counter increments each DWAIT cycle.
     - mem_dmem_ready=1 exits DWAIT to RUN in the same cycle; stalls deassert and the counter clears.
     - When the counter reaches MEM_TIMEOUT: bus_error=1 for one cycle, exmem_flush=1, memwb_flush=1, stalls released, return to RUN, counter cleared.
  2. Redirect (ex_take_branch=1).
     - Outputs: ifid_flush=1, idex_flush=1, pc_stall=0 so the PC loads the target; flush_count++.
     - If if_imem_ready=0 in that cycle, go to IDROP.
  3. IDROP.
     - Outputs: pc_stall=1, ifid_flush=1.
     - The stale response arriving with if_imem_ready=1 is discarded (ifid_flush=1 that cycle); then go to RUN.
  4. Load-use. Condition: ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)).
     - Outputs: pc_stall=1, ifid_stall=1, idex_flush=1.
     - Exactly one bubble; the hazard clears naturally the next cycle.
     - Register x0 never causes a stall.
  5. Fetch wait (!if_imem_ready in RUN).
     - Outputs: pc_stall=1, ifid_flush=1.
     - Downstream stages advance.
     - Load-use and fetch wait may coincide: stall and flush are both applied to IF/ID, and flush wins at the register.
- Simultaneous events:
  - Taken branch with a load-use hazard: branch wins; the ID instruction is squashed.
  - Branch while data stall: branch ignored, re-evaluated after the wait.
- stall_count increments on every cycle pc_stall=1.
- Both counters wrap at 2^CNT_W.

Test Plan:
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → exactly one cycle of pc_stall=1, ifid_stall=1, idex_flush=1. Same with rd=x0 → no stall.
- Taken branch with if_imem_ready=1 → ifid_flush=1 and idex_flush=1 for one cycle, pc_stall=0, flush_count 0→1.
- Taken branch with if_imem_ready=0, then ready 3 cycles later → IDROP for 3 cycles with pc_stall=1 and ifid_flush=1. The fourth cycle's response is flushed, then RUN.
- Store with mem_dmem_ready low 5 cycles → pc, ifid, idex and exmem stalls and memwb_flush held 5 cycles; ex_take_branch=1 during the wait has no effect; stall_count +5.
- mem_dmem_ready never asserted → bus_error pulses on the 16th DWAIT cycle together with exmem_flush and memwb_flush; the next cycle is RUN with no stalls.
- rst asserted asynchronously mid-DWAIT → outputs 0 and counters 0 immediately; after release, state is RUN.

Source files
------------

// File: rtl/elbeth_pipeline_control.sv
// ============================================================================
// Module   : elbeth_pipeline_control
// Purpose  : Hazard and sequencing controller for the 5-stage ELBETH pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_pipeline_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_imem_ready,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_take_branch,
    input  logic             mem_dmem_request,
    input  logic             mem_dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_stall,
    output logic             memwb_flush,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int c_tcnt_w = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_tcnt_w-1:0] c_timeout = c_tcnt_w'(MEM_TIMEOUT);
    localparam logic [c_tcnt_w-1:0] c_tcnt_one = c_tcnt_w'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDROP = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                r_drop_pend;
    logic                r_bus_error;
    logic [CNT_W-1:0]    r_stall_count;
    logic [CNT_W-1:0]    r_flush_count;

    logic w_timeout;
    logic w_dwait;
    logic w_drop;
    logic w_load_use;
    logic w_redirect;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_idex_flush;
    logic w_exmem_stall;
    logic w_exmem_flush;
    logic w_memwb_flush;

    // r_tcnt counts completed wait cycles; reaching the limit in DWAIT aborts.
    assign w_timeout  = (r_state == DWAIT) && (r_tcnt == c_timeout);
    assign w_dwait    = !w_timeout && ((r_state == DWAIT) || mem_dmem_request) && !mem_dmem_ready;
    // A stale fetch response is still owed if we were dropping when the data wait began.
    assign w_drop     = (r_state == IDROP) || ((r_state == DWAIT) && r_drop_pend);
    assign w_load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                         (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign w_redirect = ex_take_branch && !w_dwait && !w_timeout;

    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        if (!rst) begin
            if (w_dwait) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_stall  = 1'b1;
                w_exmem_stall = 1'b1;
                w_memwb_flush = 1'b1;
            end else begin
                // On abort the EX instruction is squashed, so its branch and load are moot.
                if (w_timeout) begin
                    w_exmem_flush = 1'b1;
                    w_memwb_flush = 1'b1;
                end
                if (w_redirect) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_drop) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                end else if (w_load_use && !w_timeout) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                    w_ifid_flush = !if_imem_ready;
                end else if (!if_imem_ready) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_tcnt        <= '0;
            r_drop_pend   <= 1'b0;
            r_bus_error   <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, w_pc_stall};
            r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, w_redirect};
            // Raised one cycle early so the pulse coincides with the abort cycle.
            r_bus_error   <= w_dwait && ((r_tcnt + c_tcnt_one) == c_timeout);
            if (w_dwait) begin
                r_state     <= DWAIT;
                r_tcnt      <= r_tcnt + c_tcnt_one;
                r_drop_pend <= w_drop;
            end else begin
                r_tcnt      <= '0;
                r_drop_pend <= 1'b0;
                if ((w_redirect || w_drop) && !if_imem_ready) begin
                    r_state <= IDROP;
                end else begin
                    r_state <= RUN;
                end
            end
        end
    end

    assign pc_stall    = w_pc_stall;
    assign ifid_stall  = w_ifid_stall;
    assign ifid_flush  = w_ifid_flush;
    assign idex_stall  = w_idex_stall;
    assign idex_flush  = w_idex_flush;
    assign exmem_stall = w_exmem_stall;
    assign exmem_flush = w_exmem_flush;
    assign memwb_stall = 1'b0;
    assign memwb_flush = w_memwb_flush;
    assign bus_error   = r_bus_error;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_pipeline_control.sv
// ============================================================================
// Module   : tb_elbeth_pipeline_control
// Purpose  : Self-checking bench for elbeth_pipeline_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elbeth_pipeline_control;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    // Packed view: {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f, bus_error}
    localparam logic [9:0] V_IDLE = 10'b0000000000;
    localparam logic [9:0] V_LU   = 10'b1100100000;
    localparam logic [9:0] V_LUFW = 10'b1110100000;
    localparam logic [9:0] V_BR   = 10'b0010100000;
    localparam logic [9:0] V_FW   = 10'b1010000000;
    localparam logic [9:0] V_DW   = 10'b1101010010;
    localparam logic [9:0] V_TO   = 10'b0000001011;

    logic clk = 1'b0;
    logic rst;
    logic if_imem_ready, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_take_branch;
    logic mem_dmem_request, mem_dmem_ready;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, memwb_stall, memwb_flush, bus_error;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [9:0] obs;

    int errors = 0;
    int checks = 0;

    // Reference model: consecutive wait cycles, owed stale fetch, and event tallies.
    int               m_wait;
    bit               m_drop;
    logic [CNT_W-1:0] m_stall, m_flush;
    logic [9:0]       e_out;
    bit               e_wait, e_abort, e_redir;

    elbeth_pipeline_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_imem_ready(if_imem_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_take_branch(ex_take_branch),
        .mem_dmem_request(mem_dmem_request), .mem_dmem_ready(mem_dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
        .memwb_stall(memwb_stall), .memwb_flush(memwb_flush),
        .bus_error(bus_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                  exmem_stall, exmem_flush, memwb_stall, memwb_flush, bus_error};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_wait  = 0;
        m_drop  = 0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic model_eval();
        bit lu;
        bit pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, bus;
        {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, bus} = '0;
        e_abort = (m_wait == MEM_TIMEOUT);
        e_wait  = !e_abort && (m_wait > 0 || mem_dmem_request) && !mem_dmem_ready;
        lu = ex_mem_read && ex_rd_addr != 0 &&
             ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        e_redir = ex_take_branch && !e_wait && !e_abort;
        if (e_wait) begin
            {pc_s, ifid_s, idex_s, exmem_s, memwb_f} = 5'b11111;
        end else begin
            if (e_abort) {exmem_f, memwb_f, bus} = 3'b111;
            if (e_redir) {ifid_f, idex_f} = 2'b11;
            else if (m_drop) {pc_s, ifid_f} = 2'b11;
            else if (lu && !e_abort) begin
                {pc_s, ifid_s, idex_f} = 3'b111;
                ifid_f = !if_imem_ready;
            end else if (!if_imem_ready) {pc_s, ifid_f} = 2'b11;
        end
        e_out = rst ? V_IDLE : {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, 1'b0, memwb_f, bus};
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            m_stall = m_stall + CNT_W'(e_out[9]);
            m_flush = m_flush + CNT_W'(e_redir);
            if (e_wait) begin
                m_wait = m_wait + 1;
            end else begin
                m_wait = 0;
                m_drop = (e_redir || m_drop) ? !if_imem_ready : 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        if_imem_ready = 1; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd_addr = 0; ex_mem_read = 0; ex_take_branch = 0; mem_dmem_request = 0; mem_dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        if_imem_ready = 0; mem_dmem_request = 1; mem_dmem_ready = 0; ex_take_branch = 1;
        ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1; id_rs2_addr = 0; id_uses_rs2 = 0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, V_IDLE); end
        checks++;
        if (stall_count !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        idle();
    endtask

    task automatic test_load_use();
        idle(); ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1; id_rs2_addr = 1; id_uses_rs2 = 1;
        #1; checks++;
        if (obs !== V_LU) begin errors++; $display("FAIL load_use_rs1 got=%b want=%b", obs, V_LU); end
        tick();
        ex_mem_read = 0; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_clears got=%b want=%b", obs, V_IDLE); end
        tick();
        ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_x0 got=%b want=%b", obs, V_IDLE); end
        tick();
        ex_rd_addr = 7; id_rs1_addr = 2; id_rs2_addr = 7; #1; checks++;
        if (obs !== V_LU) begin errors++; $display("FAIL load_use_rs2 got=%b want=%b", obs, V_LU); end
        tick();
        id_uses_rs2 = 0; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_unused got=%b want=%b", obs, V_IDLE); end
        tick();
        id_uses_rs2 = 1; if_imem_ready = 0; #1; checks++;
        if (obs !== V_LUFW) begin errors++; $display("FAIL load_use_fetchwait got=%b want=%b", obs, V_LUFW); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        idle(); #1; checks++;
        if (flush_count !== 0) begin errors++; $display("FAIL flush_count_start got=%0d want=0", flush_count); end
        ex_take_branch = 1; #1; checks++;
        if (obs !== V_BR) begin errors++; $display("FAIL branch got=%b want=%b", obs, V_BR); end
        tick();
        ex_take_branch = 0; #1; checks++;
        if (flush_count !== 1) begin errors++; $display("FAIL flush_count_step got=%0d want=1", flush_count); end
        checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL branch_after got=%b want=%b", obs, V_IDLE); end
        ex_take_branch = 1; ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3; id_uses_rs1 = 1; #1; checks++;
        if (obs !== V_BR) begin errors++; $display("FAIL branch_over_load_use got=%b want=%b", obs, V_BR); end
        tick();
        idle();
    endtask

    task automatic test_idrop();
        idle(); ex_take_branch = 1; if_imem_ready = 0; #1; checks++;
        if (obs !== V_BR) begin errors++; $display("FAIL idrop_branch got=%b want=%b", obs, V_BR); end
        tick();
        ex_take_branch = 0;
        for (int i = 0; i < 4; i++) begin
            if_imem_ready = (i == 3); #1; checks++;
            if (obs !== V_FW) begin errors++; $display("FAIL idrop_cycle%0d got=%b want=%b", i, obs, V_FW); end
            tick();
        end
        #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL idrop_exit got=%b want=%b", obs, V_IDLE); end
        tick();
    endtask

    task automatic test_dwait();
        logic [CNT_W-1:0] s0, f0;
        idle(); s0 = m_stall; f0 = m_flush;
        for (int i = 0; i < 5; i++) begin
            mem_dmem_request = 1; mem_dmem_ready = 0; ex_take_branch = (i == 2 || i == 3);
            if_imem_ready = (i != 1); ex_mem_read = (i == 3); ex_rd_addr = 4; id_rs1_addr = 4; id_uses_rs1 = 1;
            #1; checks++;
            if (obs !== V_DW) begin errors++; $display("FAIL dwait_cycle%0d got=%b want=%b", i, obs, V_DW); end
            tick();
        end
        idle(); mem_dmem_request = 1; mem_dmem_ready = 1; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL dwait_exit got=%b want=%b", obs, V_IDLE); end
        tick();
        idle(); #1; checks++;
        if (stall_count !== s0 + 5) begin errors++; $display("FAIL dwait_stall_count got=%0d want=%0d", stall_count, s0 + 5); end
        checks++;
        if (flush_count !== f0) begin errors++; $display("FAIL dwait_branch_ignored got=%0d want=%0d", flush_count, f0); end
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        idle(); mem_dmem_request = 1;
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            exp = (i < MEM_TIMEOUT) ? V_DW : V_TO;
            #1; checks++;
            if (obs !== exp) begin errors++; $display("FAIL timeout_cycle%0d got=%b want=%b", i, obs, exp); end
            tick();
        end
        mem_dmem_request = 0; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL timeout_after got=%b want=%b", obs, V_IDLE); end
        tick();
    endtask

    task automatic test_async_reset();
        idle(); mem_dmem_request = 1;
        for (int i = 0; i < 3; i++) tick();
        #3; rst = 1; #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL async_reset_outputs got=%b want=%b", obs, V_IDLE); end
        checks++;
        if (stall_count !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL async_reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 0; idle(); #1; checks++;
        if (obs !== V_IDLE) begin errors++; $display("FAIL async_reset_run got=%b want=%b", obs, V_IDLE); end
        tick();
        if_imem_ready = 0; #1; checks++;
        if (obs !== V_FW) begin errors++; $display("FAIL async_reset_fetchwait got=%b want=%b", obs, V_FW); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int pct;
        for (int n = 0; n < 600; n++) begin
            pct = (((n / 60) % 3) == 2) ? 3 : 70;
            if_imem_ready    = ($urandom_range(0, 99) < 75);
            mem_dmem_request = ($urandom_range(0, 99) < 30);
            mem_dmem_ready   = ($urandom_range(0, 99) < pct);
            ex_take_branch   = ($urandom_range(0, 99) < 15);
            ex_mem_read      = ($urandom_range(0, 99) < 40);
            id_uses_rs1      = $urandom_range(0, 1);
            id_uses_rs2      = $urandom_range(0, 1);
            id_rs1_addr      = 5'($urandom_range(0, 3));
            id_rs2_addr      = 5'($urandom_range(0, 3));
            ex_rd_addr       = 5'($urandom_range(0, 3));
            #1; model_eval(); checks++;
            if (obs !== e_out) begin errors++; $display("FAIL random_outputs n=%0d got=%b want=%b", n, obs, e_out); end
            checks++;
            if (stall_count !== m_stall || flush_count !== m_flush) begin
                errors++;
                $display("FAIL random_counters n=%0d got=%0d/%0d want=%0d/%0d", n, stall_count, flush_count, m_stall, m_flush);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_idrop();
        test_dwait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
